fpu_addsub_param: RTL and testbench

FPU_ADDSUB_PARAM -- requirements
Module: fpu_addsub_param

---
 rtl/fpu_addsub_param_if.sv | 33 +++
 rtl/fpu_addsub_param.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fpu_addsub_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_param_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_addsub_param_if
// Brief    : Operand/result handshake bundle for fpu_addsub_param.
// Revision : 1.0
// ============================================================================
interface fpu_addsub_param_if #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
);
  localparam int c_W = 1 + EXP_W + MAN_W;

  logic           in_valid;
  logic           in_ready;
  logic [c_W-1:0] op_A_in;
  logic [c_W-1:0] op_B_in;
  logic           op_sub;
  logic           out_valid;
  logic           out_ready;
  logic [c_W-1:0] data_out;
  logic [3:0]     status_out;

  modport master (
    output in_valid, op_A_in, op_B_in, op_sub, out_ready,
    input  in_ready, out_valid, data_out, status_out
  );

  modport slave (
    input  in_valid, op_A_in, op_B_in, op_sub, out_ready,
    output in_ready, out_valid, data_out, status_out
  );
endinterface
`default_nettype wire

// File: rtl/fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : fpu_addsub_param
// Brief    : Multi-cycle parameterised floating-point add/subtract with
//            round-to-nearest-even and exact/inexact/overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module fpu_addsub_param #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  wire logic         clock100KHz,
  input  wire logic         reset,
  fpu_addsub_param_if.slave bus
);
  localparam int c_W        = 1 + EXP_W + MAN_W;
  localparam int c_XW       = MAN_W + 3;
  localparam int c_AW       = MAN_W + 5;
  localparam int c_EW       = EXP_W + 1;
  localparam int c_NORM_MAX = MAN_W + 4;
  localparam int c_CW       = $clog2(c_NORM_MAX + 1);

  localparam logic [31:0]     c_MAX_SHIFT = 32'(MAN_W + 3);
  localparam logic [c_EW-1:0] c_EXP_OVF   = c_EW'((1 << EXP_W) - 1);
  localparam logic [c_EW-1:0] c_EXP_ONE   = c_EW'(1);
  localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(c_NORM_MAX);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

  localparam logic [3:0] c_ST_EXACT   = 4'b0001;
  localparam logic [3:0] c_ST_INEXACT = 4'b0010;
  localparam logic [3:0] c_ST_OVER    = 4'b0100;
  localparam logic [3:0] c_ST_UNDER   = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ALIGN     = 3'd1,
    S_OPERATE   = 3'd2,
    S_NORMALIZE = 3'd3,
    S_ROUND     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_in_ready;
  logic   w_out_valid;

  logic [c_W-1:0]  r_a;
  logic [c_W-1:0]  r_b;
  logic [c_XW-1:0] r_big;
  logic [c_XW-1:0] r_small;
  logic            r_sticky;
  logic            r_sign;
  logic            r_sub;
  logic            r_unf;
  logic [c_EW-1:0] r_exp;
  logic [c_AW-1:0] r_acc;
  logic [c_CW-1:0] r_cnt;
  logic [c_W-1:0]  r_data;
  logic [3:0]      r_status;

  // ---------------------------------------------------------------- align
  logic              w_a_sign;
  logic              w_b_sign;
  logic [EXP_W-1:0]  w_a_exp;
  logic [EXP_W-1:0]  w_b_exp;
  logic [c_XW-1:0]   w_a_ext;
  logic [c_XW-1:0]   w_b_ext;
  logic              w_a_ge_b;
  logic [EXP_W-1:0]  w_big_exp;
  logic [EXP_W-1:0]  w_small_exp;
  logic [c_XW-1:0]   w_big_ext;
  logic [c_XW-1:0]   w_small_ext;
  logic [EXP_W-1:0]  w_d;
  logic [2*c_XW-1:0] w_wide;
  logic [c_XW-1:0]   w_aligned;
  logic              w_align_sticky;

  assign w_a_sign = r_a[c_W-1];
  assign w_b_sign = r_b[c_W-1];
  assign w_a_exp  = r_a[c_W-2 -: EXP_W];
  assign w_b_exp  = r_b[c_W-2 -: EXP_W];

  // A zero exponent means zero: mantissa is flushed and no hidden bit.
  assign w_a_ext = (w_a_exp != '0) ? {1'b1, r_a[MAN_W-1:0], 2'b00} : '0;
  assign w_b_ext = (w_b_exp != '0) ? {1'b1, r_b[MAN_W-1:0], 2'b00} : '0;

  assign w_a_ge_b    = {w_a_exp, w_a_ext} >= {w_b_exp, w_b_ext};
  assign w_big_exp   = w_a_ge_b ? w_a_exp : w_b_exp;
  assign w_small_exp = w_a_ge_b ? w_b_exp : w_a_exp;
  assign w_big_ext   = w_a_ge_b ? w_a_ext : w_b_ext;
  assign w_small_ext = w_a_ge_b ? w_b_ext : w_a_ext;
  assign w_d         = w_big_exp - w_small_exp;
  assign w_wide      = {w_small_ext, {c_XW{1'b0}}} >> w_d;

  always_comb begin
    w_aligned      = w_wide[2*c_XW-1:c_XW];
    w_align_sticky = |w_wide[c_XW-1:0];
    if (32'(w_d) > c_MAX_SHIFT) begin
      w_aligned      = '0;
      w_align_sticky = |w_small_ext;
    end
  end

  // -------------------------------------------------------------- operate
  logic [c_AW-1:0] w_op_big;
  logic [c_AW-1:0] w_op_small;
  logic [c_AW-1:0] w_op_res;

  assign w_op_big   = {1'b0, r_big, 1'b0};
  assign w_op_small = {1'b0, r_small, r_sticky};
  assign w_op_res   = r_sub ? (w_op_big - w_op_small) : (w_op_big + w_op_small);

  // ------------------------------------------------------------ normalize
  logic w_carry;
  logic w_need_left;
  logic w_exp_low;
  logic w_norm_more;

  assign w_carry     = r_acc[c_AW-1];
  assign w_need_left = !r_acc[c_AW-2] && (r_acc != '0);
  assign w_exp_low   = (r_exp <= c_EXP_ONE);
  assign w_norm_more = (w_carry || (w_need_left && !w_exp_low)) && (r_cnt != c_CNT_MAX);

  // ---------------------------------------------------------------- round
  logic [MAN_W:0]   w_mant;
  logic             w_g;
  logic             w_r;
  logic             w_s;
  logic             w_inc;
  logic [MAN_W+1:0] w_rsum;
  logic [c_EW-1:0]  w_rexp;
  logic [MAN_W-1:0] w_frac;
  logic             w_inexact;
  logic [c_W-1:0]   w_res_data;
  logic [3:0]       w_res_status;

  assign w_mant    = r_acc[c_AW-2:3];
  assign w_g       = r_acc[2];
  assign w_r       = r_acc[1];
  assign w_s       = r_acc[0];
  assign w_inc     = w_g & (w_r | w_s | w_mant[0]);
  assign w_rsum    = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_rexp    = r_exp + {{EXP_W{1'b0}}, w_rsum[MAN_W+1]};
  assign w_frac    = w_rsum[MAN_W+1] ? w_rsum[MAN_W:1] : w_rsum[MAN_W-1:0];
  assign w_inexact = w_g | w_r | w_s;

  always_comb begin
    w_res_data   = '0;
    w_res_status = c_ST_EXACT;
    if (r_unf) begin
      w_res_status = c_ST_UNDER | c_ST_INEXACT;
    end else if (r_acc == '0) begin
      w_res_status = c_ST_EXACT;
    end else if (w_rexp >= c_EXP_OVF) begin
      w_res_data   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_res_status = c_ST_OVER | c_ST_INEXACT;
    end else begin
      w_res_data   = {r_sign, w_rexp[EXP_W-1:0], w_frac};
      w_res_status = w_inexact ? c_ST_INEXACT : c_ST_EXACT;
    end
  end

  // ------------------------------------------------------------------ fsm
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_ALIGN;
      end
      S_ALIGN:     w_state_nxt = S_OPERATE;
      S_OPERATE:   w_state_nxt = S_NORMALIZE;
      S_NORMALIZE: if (!w_norm_more) w_state_nxt = S_ROUND;
      S_ROUND:     w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_big    <= '0;
      r_small  <= '0;
      r_sticky <= 1'b0;
      r_sign   <= 1'b0;
      r_sub    <= 1'b0;
      r_unf    <= 1'b0;
      r_exp    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.op_A_in;
            r_b   <= {bus.op_B_in[c_W-1] ^ bus.op_sub, bus.op_B_in[c_W-2:0]};
            r_unf <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_ALIGN: begin
          r_big    <= w_big_ext;
          r_small  <= w_aligned;
          r_sticky <= w_align_sticky;
          r_exp    <= {1'b0, w_big_exp};
          r_sign   <= w_a_ge_b ? w_a_sign : w_b_sign;
          r_sub    <= w_a_sign ^ w_b_sign;
        end
        S_OPERATE: begin
          r_acc <= w_op_res;
          // Cancellation to zero always yields +0.
          if (w_op_res == '0) r_sign <= 1'b0;
        end
        S_NORMALIZE: begin
          if (w_norm_more) begin
            r_cnt <= r_cnt + c_CNT_ONE;
            if (w_carry) begin
              r_acc <= {1'b0, r_acc[c_AW-1:2], r_acc[1] | r_acc[0]};
              r_exp <= r_exp + c_EXP_ONE;
            end else begin
              r_acc <= r_acc << 1;
              r_exp <= r_exp - c_EXP_ONE;
            end
          end else if (!w_carry && w_need_left && w_exp_low) begin
            r_unf <= 1'b1;
          end
        end
        S_ROUND: begin
          r_data   <= w_res_data;
          r_status <= w_res_status;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.data_out   = r_data;
  assign bus.status_out = r_status;
endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_addsub_param
// Brief    : Scoreboard bench for fpu_addsub_param at default parameters.
// Revision : 1.0
// ============================================================================
module tb_fpu_addsub_param;
  localparam int EXP_W = 6;
  localparam int MAN_W = 25;

  logic clock100KHz = 1'b0;
  logic reset       = 1'b0;

  always #5 clock100KHz = ~clock100KHz;

  fpu_addsub_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fpu_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .bus         (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_extra  = 0;
  int   last_lat = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Results are compared the half cycle before the handshake edge.
  always @(negedge clock100KHz) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_extra++;
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val({e.tag, "_data"}, bus.data_out, e.data);
        check_val({e.tag, "_status"}, {28'd0, bus.status_out}, {28'd0, e.status});
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] wd, input logic [3:0] ws, input string tag,
                          input bit push);
    int n;
    n = 0;
    @(negedge clock100KHz);
    while (!bus.in_ready && n < 100) begin
      @(negedge clock100KHz);
      n++;
    end
    check_val({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.op_A_in  = a;
    bus.op_B_in  = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    if (push) sb.push_back('{wd, ws, tag});
    @(posedge clock100KHz);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clock100KHz);
      #1;
      n++;
    end
    last_lat = n;
    if (!bus.out_valid) check_val({tag, "_timeout"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] wd, input logic [3:0] ws, input string tag);
    start_op(a, b, sub, wd, ws, tag, 1'b1);
    wait_out(tag);
    @(posedge clock100KHz);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op_A_in   = '0;
    bus.op_B_in   = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clock100KHz);
    #1;
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_data", bus.data_out, 32'd0);
    check_val("rst_status", {28'd0, bus.status_out}, 32'd0);
    @(negedge clock100KHz);
    reset = 1'b1;
    #1;
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001, "one_plus_one");
    check_val("latency", 32'(last_lat), 32'd5);
    run_op(32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001, "one_minus_one");
    run_op(32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010, "tie_even");
    run_op(32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0110, "overflow");
    run_op(32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'b1010, "underflow");
    run_op(32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0010, "tie_odd_up");
    run_op(32'h3E000000, 32'h08000000, 1'b0, 32'h3E000000, 4'b0010, "below_half");
    run_op(32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b0010, "far_shift");
    run_op(32'h40000000, 32'h3E000000, 1'b1, 32'h3E000000, 4'b0001, "two_minus_one");
    run_op(32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0001, "one_minus_two");
    run_op(32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b0001, "neg_add");
    run_op(32'h00000123, 32'h3F000000, 1'b0, 32'h3F000000, 4'b0001, "flushed_zero");

    // Backpressure, with a stray in_valid that must be ignored.
    bus.out_ready = 1'b0;
    start_op(32'h3F000000, 32'h3F000000, 1'b0, 32'h41000000, 4'b0001, "bp", 1'b1);
    wait_out("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock100KHz);
      if (i == 3) begin
        bus.op_A_in  = 32'h40000000;
        bus.op_B_in  = 32'h40000000;
        bus.in_valid = 1'b1;
      end
      check_val("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check_val("bp_data", bus.data_out, 32'h41000000);
      check_val("bp_status", {28'd0, bus.status_out}, 32'd1);
      check_val("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clock100KHz);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock100KHz);
    #1;

    // Reset while normalizing: no output may appear.
    start_op(32'h3E000000, 32'h3E000000, 1'b0, 32'h0, 4'b0, "abort", 1'b0);
    repeat (2) @(posedge clock100KHz);
    #1;
    reset = 1'b0;
    #1;
    check_val("abort_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("abort_data", bus.data_out, 32'd0);
    check_val("abort_status", {28'd0, bus.status_out}, 32'd0);
    @(negedge clock100KHz);
    reset = 1'b1;
    #1;
    check_val("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (8) @(posedge clock100KHz);
    #1;
    check_val("abort_no_out", {31'd0, bus.out_valid}, 32'd0);

    run_op(32'h40000000, 32'h3E000000, 1'b1, 32'h3E000000, 4'b0001, "post_reset");

    repeat (3) @(posedge clock100KHz);
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    check_val("extra_outputs", 32'(n_extra), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
